// File: rtl/hex_dump_arbiter.sv
// rtl/hex_dump_arbiter.sv - packet-granular round-robin arbiter feeding one hex_dump converter
//
// Shares one hex_dump converter between NUM_SRC byte streams. A source is granted
// for exactly one packet (through tlast). The arbiter then waits for the converter
// to finish emitting that packet before it grants again. New packets are held off
// while the converter's output FIFO level is above LEVEL_MAX.
//
// Ports:
//   clock, reset              system clock, synchronous active-high reset
//   s_tvalid/s_tready/s_tlast/s_tkeep [NUM_SRC], s_tdata [8*NUM_SRC]
//                             per-source byte streams; source i uses s_tdata[8i+7:8i]
//   d_start_o                 start request to the converter
//   d_dumping_i, d_level_i    converter busy flag and output FIFO level
//   d_tvalid/d_tready/d_tlast/d_tkeep/d_tdata
//                             muxed byte stream into the converter
//   grant_o                   registered one-hot grant
//   busy_o                    high whenever a packet is being armed, streamed or drained

module hex_dump_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int LEVEL_MAX = 1536
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_SRC-1:0]   s_tvalid,
    output logic [NUM_SRC-1:0]   s_tready,
    input  logic [NUM_SRC-1:0]   s_tlast,
    input  logic [NUM_SRC-1:0]   s_tkeep,
    input  logic [8*NUM_SRC-1:0] s_tdata,
    output logic                 d_start_o,
    input  logic                 d_dumping_i,
    input  logic [10:0]          d_level_i,
    output logic                 d_tvalid,
    output logic                 d_tlast,
    output logic                 d_tkeep,
    output logic [7:0]           d_tdata,
    input  logic                 d_tready,
    output logic [NUM_SRC-1:0]   grant_o,
    output logic                 busy_o
);

    localparam int               IDX_W     = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1;
    localparam logic [10:0]      LEVEL_LIM = 11'(LEVEL_MAX);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SRC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_STREAM,
        ST_DRAIN
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   gidx;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [NUM_SRC-1:0] win_onehot;
    logic               start_ok;
    logic               last_beat;

    // Winner search: first requesting source at or after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        int cand;
        cand      = 0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            if (!win_found && s_tvalid[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign win_onehot = NUM_SRC'(1) << win_idx;

    // The level gate and the converter-idle check apply only at packet boundaries;
    // once a packet is granted, only the converter's own back-pressure paces it.
    assign start_ok  = win_found && (d_level_i <= LEVEL_LIM) && !d_dumping_i;
    assign last_beat = d_tvalid && d_tready && d_tlast;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            gidx      <= '0;
            grant_o   <= '0;
            d_start_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        gidx      <= win_idx;
                        grant_o   <= win_onehot;
                        d_start_o <= 1'b1;
                        state     <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    // Start stays high until the converter acknowledges by raising
                    // is_dumping; it only samples start while idle, so holding it is safe.
                    if (d_dumping_i) begin
                        d_start_o <= 1'b0;
                        state     <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (last_beat) begin
                        rr_ptr <= (gidx == LAST_IDX) ? '0 : gidx + IDX_W'(1);
                        state  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Hold the grant until the converter has emitted the whole packet so
                    // dump text from different sources never interleaves.
                    if (!d_dumping_i) begin
                        grant_o <= '0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state != ST_IDLE);

    // Stream routing from the registered grant index; closed outside ARM and STREAM.
    always_comb begin
        s_tready = '0;
        d_tvalid = 1'b0;
        d_tlast  = 1'b0;
        d_tkeep  = 1'b0;
        d_tdata  = 8'h00;
        if (state == ST_ARM || state == ST_STREAM) begin
            d_tvalid       = s_tvalid[gidx];
            d_tlast        = s_tlast[gidx];
            d_tkeep        = s_tkeep[gidx];
            d_tdata        = s_tdata[{gidx, 3'b000} +: 8];
            s_tready[gidx] = d_tready;
        end
    end

endmodule

// File: tb/tb_hex_dump_arbiter.sv
// tb/tb_hex_dump_arbiter.sv - self-checking bench for hex_dump_arbiter with a behavioural converter

module tb_hex_dump_arbiter;

    localparam int N      = 4;
    localparam int LVLMAX = 1536;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  s_tvalid, s_tready, s_tlast, s_tkeep;
    logic [31:0] s_tdata;
    logic        d_start_o, d_dumping_i, d_tvalid, d_tlast, d_tkeep, d_tready, busy_o;
    logic [10:0] d_level_i;
    logic [7:0]  d_tdata;
    logic [3:0]  grant_o;

    hex_dump_arbiter #(.NUM_SRC(N), .LEVEL_MAX(LVLMAX)) dut (
        .clock(clock), .reset(reset),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tkeep(s_tkeep), .s_tdata(s_tdata),
        .d_start_o(d_start_o), .d_dumping_i(d_dumping_i), .d_level_i(d_level_i),
        .d_tvalid(d_tvalid), .d_tlast(d_tlast), .d_tkeep(d_tkeep), .d_tdata(d_tdata), .d_tready(d_tready),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Source byte buffers
    logic [7:0] sbuf  [4][64];
    bit         slast [4][64];
    int         shead [4];
    int         stail [4];

    // Converter behaviour
    bit c_busy, c_last;
    int c_tail, c_hold;

    // Reference: which source owns the converter and where the packet is in its life.
    // m_phase: 0 no packet, 1 waiting for converter to accept start, 2 moving bytes, 3 converter emitting
    int m_owner, m_phase, m_rr;

    // Observations
    logic [7:0] rcv[$];
    int         delivered[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_sources();
        for (int i = 0; i < N; i++) begin
            if (shead[i] < stail[i]) begin
                s_tvalid[i]       = 1'b1;
                s_tkeep[i]        = 1'b1;
                s_tlast[i]        = slast[i][shead[i]];
                s_tdata[8*i +: 8] = sbuf[i][shead[i]];
            end else begin
                s_tvalid[i]       = 1'b0;
                s_tkeep[i]        = 1'b0;
                s_tlast[i]        = 1'b0;
                s_tdata[8*i +: 8] = 8'h00;
            end
        end
        d_dumping_i = c_busy;
        d_tready    = c_busy && !c_last && (c_hold == 0);
    endtask

    task automatic push_seq(input int s, input int n, input int first);
        for (int k = 0; k < n; k++) begin
            sbuf[s][stail[s]]  = 8'(first + k);
            slast[s][stail[s]] = (k == n - 1);
            stail[s]++;
        end
        drive_sources();
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            shead[i] = 0;
            stail[i] = 0;
        end
        drive_sources();
    endtask

    // One clock: compare at the falling edge, advance bench state just after the rising edge.
    task automatic step();
        logic [3:0] eg, ert, sv;
        logic       ev, el, ek, dump, rst_s, start_seen, dfire_obs, dlast_obs;
        logic [7:0] ed;
        logic [10:0] lvl;
        int         popped;
        bit         found;
        @(negedge clock);
        eg  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        ev  = 1'b0; el = 1'b0; ek = 1'b0; ed = 8'h00; ert = 4'b0000;
        if (m_phase == 1 || m_phase == 2) begin
            ev           = s_tvalid[m_owner];
            el           = s_tlast[m_owner];
            ek           = s_tkeep[m_owner];
            ed           = s_tdata[8*m_owner +: 8];
            ert[m_owner] = d_tready;
        end
        chk("grant_o",  grant_o,   eg);
        chk("busy_o",   busy_o,    m_owner >= 0);
        chk("d_start_o", d_start_o, m_phase == 1);
        chk("s_tready", s_tready,  ert);
        chk("d_tvalid", d_tvalid,  ev);
        chk("d_tlast",  d_tlast,   el);
        chk("d_tkeep",  d_tkeep,   ek);
        chk("d_tdata",  d_tdata,   ed);
        sv = s_tvalid; dump = d_dumping_i; lvl = d_level_i; rst_s = reset; start_seen = d_start_o;
        dfire_obs = d_tvalid && d_tready;
        dlast_obs = d_tlast;
        popped = -1;
        for (int i = 0; i < N; i++) begin
            if (s_tvalid[i] && s_tready[i]) popped = i;
        end
        if (dfire_obs) begin
            rcv.push_back(d_tdata);
            if (dlast_obs) delivered.push_back(popped);
        end
        @(posedge clock);
        #1;
        if (rst_s) begin
            m_owner = -1; m_phase = 0; m_rr = 0;
            c_busy = 0; c_last = 0; c_tail = 0; c_hold = 0;
        end else begin
            case (m_phase)
                0: if (sv != 4'b0000 && lvl <= 11'(LVLMAX) && !dump) begin
                    found = 0;
                    for (int k = 0; k < N; k++) begin
                        if (!found && sv[(m_rr + k) % N]) begin
                            found = 1; m_owner = (m_rr + k) % N;
                        end
                    end
                    m_phase = 1;
                end
                1: if (dump) m_phase = 2;
                2: if (ev && d_tready && el) begin
                    m_rr = (m_owner + 1) % N; m_phase = 3;
                end
                3: if (!dump) begin
                    m_owner = -1; m_phase = 0;
                end
                default: ;
            endcase
            if (popped >= 0 && shead[popped] < stail[popped]) shead[popped]++;
            if (!c_busy && start_seen) begin
                c_busy = 1; c_last = 0;
            end else if (c_busy) begin
                if (!c_last && dfire_obs && dlast_obs) begin
                    c_last = 1; c_tail = 3;
                end else if (c_last) begin
                    if (c_tail > 0) c_tail--;
                    else c_busy = 0;
                end
            end
            if (c_hold > 0) c_hold--;
        end
        drive_sources();
    endtask

    task automatic wait_done(input string name);
        int cyc;
        bit done;
        cyc = 0;
        done = 0;
        while (!done && cyc < 3000) begin
            step();
            cyc++;
            done = (m_owner < 0) && !c_busy;
            for (int i = 0; i < N; i++) if (shead[i] < stail[i]) done = 0;
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles, expected completion", name, cyc);
        end
    endtask

    initial begin
        string txt;
        int    cyc;
        reset = 1'b1; d_level_i = 11'd0; s_tdata = '0; s_tvalid = '0; s_tlast = '0; s_tkeep = '0;
        c_busy = 0; c_last = 0; c_tail = 0; c_hold = 0;
        m_owner = -1; m_phase = 0; m_rr = 0;
        clear_sources();
        repeat (3) step();
        chk("reset grant_o",  grant_o,  4'b0000);
        chk("reset d_start_o", d_start_o, 1'b0);
        chk("reset busy_o",   busy_o,   1'b0);
        chk("reset s_tready", s_tready, 4'b0000);

        // Simultaneous requests from 0 and 2: 0 first, 2 untouched until 0's tlast.
        push_seq(0, 4, 8'h10);
        push_seq(2, 4, 8'h20);
        reset = 1'b0;
        step();
        chk("latency grant_o", grant_o, 4'b0001);
        chk("latency d_start_o", d_start_o, 1'b1);
        wait_done("simultaneous");
        chk("simul count", delivered.size(), 2);
        if (delivered.size() == 2) begin
            chk("simul first", delivered[0], 0);
            chk("simul second", delivered[1], 2);
        end
        chk("simul bytes", rcv.size(), 8);
        for (int j = 0; j < rcv.size() && j < 8; j++)
            chk("simul byte", rcv[j], (j < 4) ? 8'h10 + j : 8'h20 + j - 4);

        // Single source 1: 12 34 56 78
        rcv.delete(); delivered.delete();
        sbuf[1][0] = 8'h12; sbuf[1][1] = 8'h34; sbuf[1][2] = 8'h56; sbuf[1][3] = 8'h78;
        slast[1][0] = 0; slast[1][1] = 0; slast[1][2] = 0; slast[1][3] = 1;
        shead[1] = 0; stail[1] = 4;
        drive_sources();
        wait_done("single");
        txt = "";
        for (int j = 0; j + 1 < rcv.size(); j += 2) begin
            txt = {txt, $sformatf("%02x%02x", rcv[j+1], rcv[j])};
            if (j + 2 < rcv.size()) txt = {txt, " "};
        end
        txt = {txt, "\n"};
        n_chk++;
        if (txt != "3412 7856\n") begin
            n_fail++;
            $display("FAIL single text: got \"%s\" expected \"3412 7856\\n\"", txt);
        end
        chk("single count", delivered.size(), 1);
        if (delivered.size() == 1) chk("single src", delivered[0], 1);

        // Level gate on source 3
        rcv.delete(); delivered.delete();
        d_level_i = 11'(LVLMAX + 1);
        push_seq(3, 4, 8'h30);
        for (int j = 0; j < 10; j++) begin
            step();
            chk("gate start held", d_start_o, 1'b0);
        end
        d_level_i = 11'(LVLMAX);
        step();
        chk("gate grant", grant_o, 4'b1000);
        chk("gate start", d_start_o, 1'b1);
        wait_done("level gate");
        d_level_i = 11'd0;

        // Round robin: all four sources, two 2-byte packets each
        rcv.delete(); delivered.delete();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++) push_seq(i, 2, 8'h40 + 16*i + 2*p);
        wait_done("round robin");
        chk("rr count", delivered.size(), 8);
        for (int j = 0; j < delivered.size(); j++) chk("rr order", delivered[j], j % 4);

        // Back-pressure: converter stalls 200 cycles mid-packet
        rcv.delete(); delivered.delete();
        push_seq(0, 6, 8'hA0);
        cyc = 0;
        while (rcv.size() < 2 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("bp reached mid", rcv.size(), 2);
        c_hold = 200;
        drive_sources();
        for (int j = 0; j < 200; j++) begin
            step();
            chk("bp grant held", grant_o, 4'b0001);
        end
        wait_done("backpressure");
        chk("bp bytes", rcv.size(), 6);
        for (int j = 0; j < rcv.size() && j < 6; j++) chk("bp byte", rcv[j], 8'hA0 + j);

        // Reset mid-packet: pointer returns to 0
        push_seq(2, 2, 8'hB0);
        wait_done("pre-reset pkt");
        push_seq(3, 6, 8'hC0);
        cyc = 0;
        while (m_phase != 2 && cyc < 100) begin
            step();
            cyc++;
        end
        step();
        chk("mid stream busy", busy_o, 1'b1);
        reset = 1'b1;
        clear_sources();
        step();
        reset = 1'b0;
        chk("rst grant_o", grant_o, 4'b0000);
        chk("rst d_start_o", d_start_o, 1'b0);
        chk("rst busy_o", busy_o, 1'b0);
        chk("rst d_tvalid", d_tvalid, 1'b0);
        chk("rst s_tready", s_tready, 4'b0000);
        rcv.delete(); delivered.delete();
        push_seq(3, 2, 8'hD0);
        push_seq(2, 2, 8'hE0);
        wait_done("after reset");
        chk("rst count", delivered.size(), 2);
        if (delivered.size() == 2) begin
            chk("rst first", delivered[0], 2);
            chk("rst second", delivered[1], 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
